key_sched_ctrl: RTL and testbench
=================================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter KEY_LEN, default 128, cipher/round-key width (AES-128 only).
REQ-002 SHALL have parameter WORD_LEN, default 32, key-word width.
REQ-003 SHALL have parameter NR, default 10, number of generated round keys.
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles per round.
REQ-005 SHALL have a single clock and a synchronous, active-high reset; reset is sampled only on the clk rising edge.
REQ-006 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to expand cipher_key.
REQ-009 SHALL have port cipher_key, input, KEY_LEN, round-0 key, sampled with start.
REQ-010 SHALL have port sk_data, output, KEY_LEN, previous round key sent to the subkey generator.
REQ-011 SHALL have port sk_valid, output, 1, one-cycle strobe qualifying sk_data/sk_rcon/sk_opcode.
REQ-012 SHALL have port sk_rcon, output, WORD_LEN, round constant, constant byte in bits [31:24], bits [23:0] zero.
REQ-013 SHALL have port sk_opcode, output, 1, always 0 (RotWord+SubWord path).
REQ-014 SHALL have port sk_result, input, KEY_LEN, next round key from the generator.
REQ-015 SHALL have port sk_result_valid, input, 1, qualifies sk_result.
REQ-016 SHALL have port rk_addr, input, 4, round-key read index 0..NR.
REQ-017 SHALL have port rk_data, output, KEY_LEN, registered read data.
REQ-018 SHALL have port busy, output, 1, high while expansion is in progress.
REQ-019 SHALL have port done, output, 1, one-cycle pulse on successful completion.
REQ-020 SHALL have port key_ready, output, 1, all NR+1 keys valid.
REQ-021 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE; a 4-bit round counter rnd; and storage rk[0..NR].
REQ-023 SHALL, in IDLE with start=1, store cipher_key into rk[0], set rnd=1, clear key_ready and err, and go to ISSUE.
REQ-024 SHALL, in ISSUE, drive sk_valid=1 for exactly that cycle with sk_data=rk[rnd-1] and sk_rcon=Rcon[rnd], then go to WAIT.
REQ-025 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36 (hex, placed in the MSB byte).
REQ-026 SHALL, in WAIT with sk_result_valid=1, store sk_result into rk[rnd]; if rnd==NR go to DONE, else increment rnd and go to ISSUE.
REQ-027 SHALL have a WAIT cycle counter that reaches TIMEOUT without sk_result_valid: set err=1, go to IDLE, no done, key_ready stays 0.
REQ-028 SHALL, in DONE, pulse done=1 for one cycle, set key_ready=1, and go to IDLE.
REQ-029 SHALL hold busy=1 in ISSUE and WAIT, else 0.
REQ-030 SHALL ignore start while busy=1 or in DONE.
REQ-031 SHALL ignore sk_result_valid in IDLE, ISSUE and DONE.
REQ-032 SHALL hold sk_data/sk_rcon at last values when sk_valid=0; consumers must qualify with sk_valid.
REQ-033 SHALL register rk_data = rk[rk_addr] one cycle after rk_addr; rk_addr>NR returns 0; reads are allowed at any time and return current storage.
REQ-034 SHALL take NR*(L+1)+1 cycles from the start cycle to the done cycle, where L = generator latency from its sk_valid cycle to its sk_result_valid cycle.

Reset
REQ-035 SHALL, on reset=1, set state=IDLE, rnd=0, all rk=0, rk_data=0, and sk_data, sk_rcon, sk_valid, sk_opcode, busy, done, key_ready and err all to 0.
REQ-036 SHALL, on reset during ISSUE/WAIT, abort expansion; a sk_result_valid arriving after reset SHALL be ignored.

Verification
REQ-037 SHALL cover: start with cipher_key 2b7e1516_28aed2a6_abf71588_09cf4f3c and a generator model, L=4 -> done at cycle 51; rk[1]=a0fafe17_88542cb1_23a33939_2a6c7605; rk[10]=d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
REQ-038 SHALL cover: monitoring sk_rcon at each of the 10 sk_valid strobes -> 01000000,02000000,...,1B000000,36000000; exactly 10 strobes; sk_opcode always 0.
REQ-039 SHALL cover: generator never responding -> err=1 at 64 WAIT cycles after the first strobe; busy=0, done never pulses; the next start clears err.
REQ-040 SHALL cover: start re-asserted during busy and spurious sk_result_valid in IDLE -> no restart, storage unchanged, single done pulse.
REQ-041 SHALL cover: reset asserted during round 5 WAIT -> all outputs 0 next cycle; rk_addr=3 reads 0; a late sk_result_valid is ignored.
REQ-042 SHALL cover: rk_addr=11..15 -> rk_data=0; rk_addr=0 after completion -> cipher_key.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule controller: sequences an external subkey generator round by round,
// stores the NR+1 round keys and serves registered reads of them.
module key_sched_ctrl #(
    parameter int unsigned KEY_LEN  = 128,
    parameter int unsigned WORD_LEN = 32,
    parameter int unsigned NR       = 10,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [KEY_LEN-1:0]  cipher_key,
    output logic [KEY_LEN-1:0]  sk_data,
    output logic                sk_valid,
    output logic [WORD_LEN-1:0] sk_rcon,
    output logic                sk_opcode,
    input  logic [KEY_LEN-1:0]  sk_result,
    input  logic                sk_result_valid,
    input  logic [3:0]          rk_addr,
    output logic [KEY_LEN-1:0]  rk_data,
    output logic                busy,
    output logic                done,
    output logic                key_ready,
    output logic                err
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam int unsigned    CntW     = $clog2(TIMEOUT + 1);
    localparam logic [3:0]     LastRnd  = 4'(NR);
    localparam logic [CntW-1:0] LastWait = CntW'(TIMEOUT - 1);

    function automatic logic [WORD_LEN-1:0] rcon_word(input logic [3:0] r);
        logic [7:0] b;
        case (r)
            4'd1:    b = 8'h01;
            4'd2:    b = 8'h02;
            4'd3:    b = 8'h04;
            4'd4:    b = 8'h08;
            4'd5:    b = 8'h10;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h40;
            4'd8:    b = 8'h80;
            4'd9:    b = 8'h1b;
            4'd10:   b = 8'h36;
            default: b = 8'h00;
        endcase
        return {b, {(WORD_LEN - 8){1'b0}}};
    endfunction

    logic [1:0]          state_q, state_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [CntW-1:0]     wait_cnt_q, wait_cnt_d;
    logic [KEY_LEN-1:0]  rk_q [NR+1];
    logic [KEY_LEN-1:0]  sk_data_q, sk_data_d;
    logic [WORD_LEN-1:0] sk_rcon_q, sk_rcon_d;
    logic                key_ready_q, key_ready_d;
    logic                err_q, err_d;
    logic [KEY_LEN-1:0]  rk_data_q;
    logic                rk_we;
    logic [3:0]          rk_wa;
    logic [KEY_LEN-1:0]  rk_wd;

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        wait_cnt_d  = wait_cnt_q;
        sk_data_d   = sk_data_q;
        sk_rcon_d   = sk_rcon_q;
        key_ready_d = key_ready_q;
        err_d       = err_q;
        rk_we       = 1'b0;
        rk_wa       = rnd_q;
        rk_wd       = sk_result;
        case (state_q)
            StIdle: begin
                if (start) begin
                    rk_we       = 1'b1;
                    rk_wa       = 4'd0;
                    rk_wd       = cipher_key;
                    rnd_d       = 4'd1;
                    key_ready_d = 1'b0;
                    err_d       = 1'b0;
                    sk_data_d   = cipher_key;
                    sk_rcon_d   = rcon_word(4'd1);
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (sk_result_valid) begin
                    rk_we = 1'b1;
                    if (rnd_q == LastRnd) begin
                        // key_ready rises together with the done pulse
                        key_ready_d = 1'b1;
                        state_d     = StDone;
                    end else begin
                        // the freshly returned key is next round's input
                        rnd_d     = rnd_q + 4'd1;
                        sk_data_d = sk_result;
                        sk_rcon_d = rcon_word(rnd_q + 4'd1);
                        state_d   = StIssue;
                    end
                end else if (wait_cnt_q == LastWait) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            rnd_q       <= '0;
            wait_cnt_q  <= '0;
            sk_data_q   <= '0;
            sk_rcon_q   <= '0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
            rk_data_q   <= '0;
            for (int unsigned i = 0; i < NR + 1; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            wait_cnt_q  <= wait_cnt_d;
            sk_data_q   <= sk_data_d;
            sk_rcon_q   <= sk_rcon_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
            rk_data_q   <= (rk_addr <= LastRnd) ? rk_q[rk_addr] : '0;
            if (rk_we) begin
                rk_q[rk_wa] <= rk_wd;
            end
        end
    end

    assign sk_data   = sk_data_q;
    assign sk_rcon   = sk_rcon_q;
    assign sk_valid  = (state_q == StIssue);
    assign sk_opcode = 1'b0;
    assign busy      = (state_q == StIssue) || (state_q == StWait);
    assign done      = (state_q == StDone);
    assign key_ready = key_ready_q;
    assign err       = err_q;
    assign rk_data   = rk_data_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: AES key-expansion generator model plus an event-level model
// of the expected handshake, storage and status outputs, checked every cycle.
module tb_key_sched_ctrl;
    localparam int NR      = 10;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] cipher_key = '0;
    logic [127:0] sk_result = '0;
    logic         sk_result_valid = 1'b0;
    logic [3:0]   rk_addr = '0;
    logic [127:0] sk_data;
    logic         sk_valid;
    logic [31:0]  sk_rcon;
    logic         sk_opcode;
    logic [127:0] rk_data;
    logic         busy, done, key_ready, err;

    key_sched_ctrl #(
        .KEY_LEN (128),
        .WORD_LEN(32),
        .NR      (NR),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cipher_key     (cipher_key),
        .sk_data        (sk_data),
        .sk_valid       (sk_valid),
        .sk_rcon        (sk_rcon),
        .sk_opcode      (sk_opcode),
        .sk_result      (sk_result),
        .sk_result_valid(sk_result_valid),
        .rk_addr        (rk_addr),
        .rk_data        (rk_data),
        .busy           (busy),
        .done           (done),
        .key_ready      (key_ready),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AES-128 arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [7:0] rcon_of(input int r);
        logic [7:0] rc = 8'h01;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    // ---------------- subkey generator ----------------
    logic gen_en   = 1'b1;
    logic gen_rand = 1'b0;
    int   gen_lat  = 4;

    initial begin
        logic [127:0] k;
        int l;
        forever begin
            @(negedge clk);
            if (sk_valid === 1'b1 && gen_en) begin
                k = aes_next(sk_data, sk_rcon[31:24]);
                l = gen_rand ? int'($urandom_range(1, 6)) : gen_lat;
                repeat (l) @(posedge clk);
                #1;
                sk_result       = k;
                sk_result_valid = 1'b1;
                @(posedge clk);
                #1;
                sk_result_valid = 1'b0;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // The run is described by when the next strobe is due and which round it serves.
    logic         m_active = 1'b0;
    int           m_round = 0;
    int           m_strobe = -1;
    int           m_done_cyc = -1;
    logic [127:0] m_keys [0:10];
    logic         m_kr = 1'b0;
    logic         m_err = 1'b0;
    logic [127:0] m_skd = '0;
    logic [31:0]  m_rcon = '0;
    logic [127:0] m_rkd = '0;

    always @(posedge clk) begin
        int c;
        c = cyc;
        if (reset) begin
            m_active = 1'b0;
            m_round = 0;
            m_kr = 1'b0;
            m_err = 1'b0;
            m_skd = '0;
            m_rcon = '0;
            m_rkd = '0;
            m_done_cyc = -1;
            for (int i = 0; i <= NR; i++) m_keys[i] = '0;
        end else begin
            m_rkd = (int'(rk_addr) <= NR) ? m_keys[rk_addr] : '0;
            if (m_active) begin
                if (c > m_strobe) begin
                    if (sk_result_valid) begin
                        m_keys[m_round] = sk_result;
                        if (m_round == NR) begin
                            m_active = 1'b0;
                            m_done_cyc = c + 1;
                            m_kr = 1'b1;
                        end else begin
                            m_round++;
                            m_strobe = c + 1;
                            m_skd = sk_result;
                            m_rcon = {rcon_of(m_round), 24'h0};
                        end
                    end else if (c - m_strobe == TIMEOUT) begin
                        m_active = 1'b0;
                        m_err = 1'b1;
                    end
                end
            end else if (start && c != m_done_cyc) begin
                m_keys[0] = cipher_key;
                m_round = 1;
                m_strobe = c + 1;
                m_active = 1'b1;
                m_err = 1'b0;
                m_kr = 1'b0;
                m_skd = cipher_key;
                m_rcon = {rcon_of(1), 24'h0};
            end
        end
        cyc = cyc + 1;
    end

    // ---------------- per-cycle compare ----------------
    logic [31:0] strobe_log[$];
    int   n_done = 0;
    int   last_done_cyc = -1;
    int   last_strobe_cyc = -1;
    int   err_rise_cyc = -1;
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("sk_valid", 128'(sk_valid), 128'(m_active && cyc == m_strobe));
            check("busy", 128'(busy), 128'(m_active));
            check("done", 128'(done), 128'(cyc == m_done_cyc));
            check("key_ready", 128'(key_ready), 128'(m_kr));
            check("err", 128'(err), 128'(m_err));
            check("sk_opcode", 128'(sk_opcode), 128'd0);
            check("sk_data", sk_data, m_skd);
            check("sk_rcon", 128'(sk_rcon), 128'(m_rcon));
            check("rk_data", rk_data, m_rkd);
            if (sk_valid) begin
                strobe_log.push_back(sk_rcon);
                last_strobe_cyc = cyc;
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (err && !err_prev) err_rise_cyc = cyc;
            err_prev = err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int start_cyc = 0;

    task automatic pulse_start(input logic [127:0] key);
        start_cyc = cyc;
        cipher_key = key;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (m_active && k < budget) begin
            step(1);
            k++;
        end
        check("idle_within_budget", 128'(busy), 128'd0);
        step(2);
    endtask

    task automatic read_rk(input int a, input logic [127:0] exp, input string name);
        rk_addr = 4'(a);
        step(1);
        check(name, rk_data, exp);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] key0, exp, k;
        logic [31:0]  rc_exp [10];
        int d0, k_cnt;
        key0 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
        rc_exp = '{32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
                   32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000};

        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_rk_data", rk_data, 128'd0);
        check("rst_sk_valid", 128'(sk_valid), 128'd0);
        reset = 1'b0;
        step(2);

        // Pin the generator model against the published FIPS-197 expansion.
        check("model_rk1", aes_next(key0, rcon_of(1)), 128'ha0fafe17_88542cb1_23a33939_2a6c7605);

        // Known vector, fixed latency 4.
        strobe_log.delete();
        d0 = n_done;
        pulse_start(key0);
        wait_idle(200);
        check("done_latency", 128'(last_done_cyc - start_cyc), 128'd51);
        check("done_count", 128'(n_done - d0), 128'd1);
        check("strobe_count", 128'(strobe_log.size()), 128'd10);
        if (strobe_log.size() == 10) begin
            for (int i = 0; i < 10; i++) check("strobe_rcon", 128'(strobe_log[i]), 128'(rc_exp[i]));
        end
        check("key_ready_after_done", 128'(key_ready), 128'd1);
        read_rk(1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605, "rk1_vector");
        read_rk(10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "rk10_vector");
        read_rk(0, key0, "rk0_vector");
        for (int a = 11; a < 16; a++) read_rk(a, 128'd0, "rk_out_of_range");

        // Spurious results while idle must not touch storage or pulse done.
        d0 = n_done;
        sk_result = rand128();
        sk_result_valid = 1'b1;
        step(3);
        sk_result_valid = 1'b0;
        read_rk(10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6, "rk10_after_spurious");
        check("no_done_spurious", 128'(n_done - d0), 128'd0);

        // Random keys, random generator latency, random reads and ignored restarts.
        gen_rand = 1'b1;
        for (int it = 0; it < 12; it++) begin
            k = rand128();
            d0 = n_done;
            pulse_start(k);
            k_cnt = 0;
            while ((m_active || cyc == m_done_cyc) && k_cnt < 500) begin
                rk_addr = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 9) == 0) begin
                    start = 1'b1;
                    cipher_key = rand128();
                end else begin
                    start = 1'b0;
                end
                step(1);
                k_cnt++;
            end
            start = 1'b0;
            step(2);
            check("rand_single_done", 128'(n_done - d0), 128'd1);
            exp = k;
            for (int a = 0; a <= NR; a++) begin
                read_rk(a, exp, "rand_rk_chain");
                exp = aes_next(exp, rcon_of(a + 1));
            end
        end

        // Generator silent: timeout, then the next start clears err.
        gen_en = 1'b0;
        d0 = n_done;
        pulse_start(rand128());
        wait_idle(200);
        check("timeout_latency", 128'(err_rise_cyc - last_strobe_cyc), 128'(TIMEOUT + 1));
        check("timeout_err", 128'(err), 128'd1);
        check("timeout_key_ready", 128'(key_ready), 128'd0);
        check("timeout_no_done", 128'(n_done - d0), 128'd0);
        gen_en = 1'b1;
        pulse_start(rand128());
        check("err_cleared_by_start", 128'(err), 128'd0);
        wait_idle(500);
        check("key_ready_after_retry", 128'(key_ready), 128'd1);

        // Reset in the round-5 wait; the late result must be ignored.
        gen_rand = 1'b0;
        gen_lat = 4;
        d0 = n_done;
        pulse_start(rand128());
        k_cnt = 0;
        while (!(m_active && m_round == 5 && cyc > m_strobe) && k_cnt < 300) begin
            step(1);
            k_cnt++;
        end
        check("reached_round5_wait", 128'(busy), 128'd1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("rst_mid_busy", 128'(busy), 128'd0);
        check("rst_mid_sk_data", sk_data, 128'd0);
        check("rst_mid_sk_rcon", 128'(sk_rcon), 128'd0);
        check("rst_mid_key_ready", 128'(key_ready), 128'd0);
        read_rk(3, 128'd0, "rst_mid_rk3");
        step(8);
        check("late_result_ignored", 128'(busy), 128'd0);
        read_rk(5, 128'd0, "rst_mid_rk5");
        check("rst_mid_no_done", 128'(n_done - d0), 128'd0);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
